// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register-write receiver.
package spi_reg_pkg;

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned DATA_W  = 8;

    localparam logic [4:0] CNT_FULL = 5'd16;
    localparam logic [4:0] CNT_SAT  = 5'd17;

    localparam int unsigned ADDR_EN_OUT_7_0  = 0;
    localparam int unsigned ADDR_EN_OUT_15_8 = 1;
    localparam int unsigned ADDR_EN_PWM_7_0  = 2;
    localparam int unsigned ADDR_EN_PWM_15_8 = 3;
    localparam int unsigned ADDR_PWM_DUTY    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage flip-flop synchroniser with a configurable reset value.
module spi_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-write receiver driving the PWM control registers.
// Define SPI_REG_READBACK_EN to add the cipo readback path.
module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ncs,
    input  logic       sclk,
    input  logic       copi,
`ifdef SPI_REG_READBACK_EN
    output logic       cipo,
`endif
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    logic                   ncs_s, sclk_s, copi_s;
    logic                   ncs_d, sclk_d;
    logic                   ncs_rise, sclk_rise;
    logic [SYNC_STAGES-1:0] flush;
    logic                   armed;
    spi_state_t             state;
    logic [4:0]             bit_cnt;
    logic [FRAME_W-1:0]     shreg;
    logic [DATA_W-1:0]      regs [NUM_REGS];

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d(ncs), .q(ncs_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d(copi), .q(copi_s)
    );

    assign ncs_rise  = ncs_s & ~ncs_d;
    assign sclk_rise = sclk_s & ~sclk_d;

    // ncs_s shows its reset value until the synchroniser has flushed; a real
    // high must be seen before a frame may start, so a frame cut by reset is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_d   <= 1'b1;
            sclk_d  <= 1'b0;
            flush   <= '0;
            armed   <= 1'b0;
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            ncs_d  <= ncs_s;
            sclk_d <= sclk_s;
            flush  <= {flush[SYNC_STAGES-2:0], 1'b1};
            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    shreg   <= '0;
                    if (flush[SYNC_STAGES-1]) begin
                        if (ncs_s) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (ncs_rise) begin
                        state <= ST_COMMIT;
                    end else if (sclk_rise) begin
                        shreg <= {shreg[FRAME_W-2:0], copi_s};
                        if (bit_cnt != CNT_SAT) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (bit_cnt == CNT_FULL && shreg[FRAME_W-1]) begin
                        for (int unsigned i = 0; i < NUM_REGS; i++) begin
                            if (shreg[FRAME_W-2 -: ADDR_W] == ADDR_W'(i)) begin
                                regs[i] <= shreg[DATA_W-1:0];
                            end
                        end
                    end
                    bit_cnt <= '0;
                    shreg   <= '0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign en_reg_out_7_0  = regs[ADDR_EN_OUT_7_0];
    assign en_reg_out_15_8 = regs[ADDR_EN_OUT_15_8];
    assign en_reg_pwm_7_0  = regs[ADDR_EN_PWM_7_0];
    assign en_reg_pwm_15_8 = regs[ADDR_EN_PWM_15_8];
    assign pwm_duty_cycle  = regs[ADDR_PWM_DUTY];

`ifdef SPI_REG_READBACK_EN
    logic              sclk_fall;
    logic              rd_active;
    logic [DATA_W-1:0] rd_val, rd_sh;

    assign sclk_fall = ~sclk_s & sclk_d;

    // After 8 bits shreg[7:0] holds R/W and the address.
    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (shreg[ADDR_W-1:0] == ADDR_W'(i)) begin
                rd_val = regs[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cipo      <= 1'b0;
            rd_active <= 1'b0;
            rd_sh     <= '0;
        end else if (state != ST_SHIFT || ncs_s) begin
            cipo      <= 1'b0;
            rd_active <= 1'b0;
            rd_sh     <= '0;
        end else if (sclk_fall) begin
            if (bit_cnt == 5'd8 && !shreg[DATA_W-1]) begin
                cipo      <= rd_val[DATA_W-1];
                rd_sh     <= {rd_val[DATA_W-2:0], 1'b0};
                rd_active <= 1'b1;
            end else if (rd_active && bit_cnt < CNT_FULL) begin
                cipo  <= rd_sh[DATA_W-1];
                rd_sh <= {rd_sh[DATA_W-2:0], 1'b0};
            end else begin
                cipo      <= 1'b0;
                rd_active <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: doc/spi_reg_slave.md
# spi_reg_slave

SPI-mode-0 register-write receiver that sits directly upstream of the PWM peripheral and drives its five 8-bit control registers. It synchronises the asynchronous `sclk`/`copi`/`ncs` pins into the `clk` domain, assembles 16-bit frames and commits valid writes to the register file. An optional readback path is compiled in by macro.

## Interface
- `NUM_REGS`, 5: number of implemented registers at addresses 0x00..NUM_REGS-1.
- `SYNC_STAGES`, 2: flip-flop stages per input synchroniser, minimum 2.
- `clk` input 1: system clock; all state is clocked on its rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `ncs` input 1: SPI chip select, active-low, asynchronous to `clk`.
- `sclk` input 1: SPI clock, asynchronous to `clk`.
- `copi` input 1: SPI data in, sampled on synchronised `sclk` rising edge.
- `cipo` output 1: SPI data out; present only with `SPI_REG_READBACK_EN`.
- `en_reg_out_7_0` output 8: register 0x00.
- `en_reg_out_15_8` output 8: register 0x01.
- `en_reg_pwm_7_0` output 8: register 0x02.
- `en_reg_pwm_15_8` output 8: register 0x03.
- `pwm_duty_cycle` output 8: register 0x04.

## Operation
- Frame is 16 bits, MSB first: bit15 = R/W (1 = write), bits14:8 = 7-bit address, bits7:0 = data.
- Each pin passes through a `SYNC_STAGES` synchroniser; edge detection compares the synchroniser output with a one-cycle-delayed copy.
- While synchronised `ncs` is high: bit counter and shift register are held at 0; `sclk` edges are ignored.
- Each synchronised `sclk` rising edge while `ncs` low: shift in `copi`, increment 5-bit counter, saturating at 17.
- On synchronised `ncs` rising edge: commit iff counter == 16, bit15 == 1 and address < `NUM_REGS`; the addressed register takes data bits7:0. All other frames (short, long, read, out-of-range address) are discarded with no register change.
- FSM states: IDLE (ncs high) -> SHIFT (ncs low) -> COMMIT (one cycle, on ncs rise) -> IDLE. `ncs` rising from SHIFT always passes through COMMIT, where the checks above are applied.
- Reset: all five registers 0x00, counter 0, shift register 0, FSM IDLE, `cipo` 0. Reset asserted mid-frame aborts the frame; the next frame starts cleanly after `ncs` has been observed high.
- Register outputs drive flops directly; there is no combinational path from pins to outputs.

## Timing
- With `SYNC_STAGES`=2, the register output updates on the 3rd `clk` rising edge after the first edge that samples `ncs` high.
- `sclk` high and low phases must each be >= `SYNC_STAGES`+1 `clk` periods; `clk` >= 6x `sclk` is guaranteed correct.
- `copi` must be stable from `SYNC_STAGES`+1 cycles before to 1 cycle after the `sclk` rising edge; `ncs` low-to-first-`sclk`-edge and last-edge-to-`ncs`-high >= `SYNC_STAGES`+1 cycles.
- A `sclk` rising edge and an `ncs` rising edge detected in the same cycle: `ncs` wins and the bit is not shifted.
- Back-to-back frames need `ncs` high for >= `SYNC_STAGES`+2 cycles.

## Configuration
- `SPI_REG_READBACK_EN` defined: `cipo` exists. For a frame with bit15 == 0, after the 8th bit the addressed register is loaded into a read shift register. It is shifted out MSB first, updating on each synchronised `sclk` falling edge for bits 8..15. Out-of-range addresses return 0x00. `cipo` is 0 outside the data phase and while `ncs` is high. Write behaviour is unchanged.
- Not defined: no `cipo` port and no read logic; read frames are silently discarded.

## Structure
- Shared package `spi_reg_pkg`: frame width (16), address width (7), register address constants `ADDR_EN_OUT_7_0`..`ADDR_PWM_DUTY` (0x00..0x04), FSM state enum.
- One sub-module: `spi_sync`, a parameterised `SYNC_STAGES` flip-flop synchroniser with async active-low reset value. It is instantiated once per pin; the `ncs` instance resets to 1.

## Test plan
- Reset, then write 0x00<-0xFF, 0x04<-0x80 at `clk`=10x `sclk` -> `en_reg_out_7_0`=0xFF, `pwm_duty_cycle`=0x80, others 0x00; update exactly 3 edges after the `ncs` rise.
- Write address 0x05 data 0xAA, then address 0x7F data 0x55 -> all registers unchanged.
- 15-bit frame and 17-bit frame to address 0x01 data 0x3C -> `en_reg_out_15_8` stays 0x00; a following proper 16-bit frame -> 0x3C.
- Read frame (bit15=0) to 0x02: without macro, registers unchanged. With macro, after writing 0x02<-0xA5, a read returns 0xA5 on `cipo` MSB first.
- Assert `rst_n` after 9 bits of a write to 0x03 -> all registers 0x00, no commit; the next full write to 0x03 of 0x0F lands correctly.
- Back-to-back writes with the minimum `ncs` high gap -> both commit, in order.
